tt_um_vhdl_fsm: RTL and testbench

Tiny Tapeout user tile that implements a serial "1011" sequence detector as a Moore FSM, with overlapping matches allowed.
- Serial bits arrive on ui_in[0], qualified by a valid strobe.
- The tile reports the current FSM state, a detect flag and a 4-bit wrap-around match counter on uo_out.
- Bidirectional pins are unused and held as inputs.

---
 rtl/tt_um_vhdl_fsm_pkg.sv | 19 +
 rtl/tt_um_vhdl_fsm_seq_detect_fsm.sv | 66 ++++++
 rtl/tt_um_vhdl_fsm.sv | 47 ++++
 tb/tb_tt_um_vhdl_fsm.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tt_um_vhdl_fsm_pkg.sv
// Shared definitions for the "1011" serial sequence detector tile.
//   state_e  : 3-bit state encoding, IDLE..MATCH (codes 5-7 unused)
//   PATTERN  : the detected bit pattern, MSB first in time
package tt_um_vhdl_fsm_pkg;

  localparam int STATE_W = 3;
  localparam int COUNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S10   = 3'd2,
    ST_S101  = 3'd3,
    ST_MATCH = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/tt_um_vhdl_fsm_seq_detect_fsm.sv
// Moore FSM detecting "1011" (overlapping) on a qualified serial bit stream,
// plus a wrap-around count of matches.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   sample  : bit qualifier; state and count hold when low
//   bit_in  : serial data bit
//   state   : current state code
//   detect  : high while in MATCH
//   count   : number of entries into MATCH, modulo 16
//
// state    | meaning
// ---------+-----------------------------------------
// IDLE  (0)| nothing useful seen
// S1    (1)| seen "1"
// S10   (2)| seen "10"
// S101  (3)| seen "101"
// MATCH (4)| seen "1011"; detect asserted
// 5..7     | unreachable; forced back to IDLE
module seq_detect_fsm
  import tt_um_vhdl_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic               bit_in,
  output logic [STATE_W-1:0] state,
  output logic               detect,
  output logic [COUNT_W-1:0] count
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE:  if (sample) state_d = bit_in ? ST_S1    : ST_IDLE;
      ST_S1:    if (sample) state_d = bit_in ? ST_S1    : ST_S10;
      ST_S10:   if (sample) state_d = bit_in ? ST_S101  : ST_IDLE;
      ST_S101:  if (sample) state_d = bit_in ? ST_MATCH : ST_S10;
      // After a match the trailing "1" is kept, so "10" can start a new one.
      ST_MATCH: if (sample) state_d = bit_in ? ST_S1    : ST_S10;
      default:  state_d = ST_IDLE;
    endcase
    // Only an actual entry counts; a stall inside MATCH keeps state_d == MATCH.
    if ((state_d == ST_MATCH) && (state_q != ST_MATCH)) begin
      count_d = count_q + 4'd1;
    end
  end

  assign state  = state_q;
  assign detect = (state_q == ST_MATCH);
  assign count  = count_q;

endmodule

// File: rtl/tt_um_vhdl_fsm.sv
// Tiny Tapeout tile wrapping the "1011" sequence detector.
//   clk     : system clock
//   rst_n   : synchronous reset, active HIGH despite the name
//   ena     : tile enable, gates bit sampling
//   ui_in   : [0] serial bit, [1] bit valid, [7:2] unused
//   uo_out  : {count[3:0], state[2:0], detect}
//   uio_in  : unused
//   uio_out : tied 0
//   uio_oe  : tied 0 (all bidirectional pins are inputs)
module tt_um_vhdl_fsm
  import tt_um_vhdl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic               sample;
  logic [STATE_W-1:0] state;
  logic               detect;
  logic [COUNT_W-1:0] count;

  assign sample = ena & ui_in[1];

  seq_detect_fsm u_fsm (
    .clk    (clk),
    .rst    (rst_n),
    .sample (sample),
    .bit_in (ui_in[0]),
    .state  (state),
    .detect (detect),
    .count  (count)
  );

  assign uo_out  = {count, state, detect};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7:2], uio_in};

endmodule

// File: tb/tb_tt_um_vhdl_fsm.sv
module tb_tt_um_vhdl_fsm;
  import tt_um_vhdl_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  tt_um_vhdl_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge (junk in ignored bits), push the
  // expected uo_out, then pop and compare 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic v, input logic b, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk);
    rst_n  = r;
    ena    = en;
    ui_in  = {6'($urandom), v, b};
    uio_in = 8'($urandom);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %02h", tag, uo_out);
    end else begin
      e = exp_q.pop_front();
      check8(tag, uo_out, e);
    end
  endtask

  task automatic bit1(input string tag, input logic b, input logic [7:0] exp);
    step(tag, 1'b0, 1'b1, 1'b1, b, exp);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c;
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset with random inputs
    do_reset("reset0");
    do_reset("reset1");
    check8("uio_out_rst", uio_out, 8'h00);
    check8("uio_oe_rst", uio_oe, 8'h00);

    // Single match
    bit1("single_b1", 1'b1, 8'h02);
    bit1("single_b2", 1'b0, 8'h04);
    bit1("single_b3", 1'b1, 8'h06);
    bit1("single_b4", 1'b1, 8'h19);

    // Overlap 1011011
    do_reset("ovl_rst");
    bit1("ovl_b1", 1'b1, 8'h02);
    bit1("ovl_b2", 1'b0, 8'h04);
    bit1("ovl_b3", 1'b1, 8'h06);
    bit1("ovl_b4", 1'b1, 8'h19);
    bit1("ovl_b5", 1'b0, 8'h14);
    bit1("ovl_b6", 1'b1, 8'h16);
    bit1("ovl_b7", 1'b1, 8'h29);

    // Stall via valid=0 and ena=0, including while in MATCH
    do_reset("stall_rst");
    bit1("stall_b1", 1'b1, 8'h02);
    bit1("stall_b2", 1'b0, 8'h04);
    step("stall_v0a", 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
    step("stall_v0b", 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
    step("stall_v0c", 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
    step("stall_en0", 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
    bit1("stall_b3", 1'b1, 8'h06);
    bit1("stall_b4", 1'b1, 8'h19);
    step("stall_match_a", 1'b0, 1'b1, 1'b0, 1'b0, 8'h19);
    step("stall_match_b", 1'b0, 1'b0, 1'b1, 1'b0, 8'h19);

    // Non-match 11100
    do_reset("nm_rst");
    bit1("nm_b1", 1'b1, 8'h02);
    bit1("nm_b2", 1'b1, 8'h02);
    bit1("nm_b3", 1'b1, 8'h02);
    bit1("nm_b4", 1'b0, 8'h04);
    bit1("nm_b5", 1'b0, 8'h00);

    // 16 matches: count wraps to 0 with detect high
    do_reset("wrap_rst");
    c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      bit1("wrap_b1", 1'b1, {c, 4'h2});
      bit1("wrap_b2", 1'b0, {c, 4'h4});
      bit1("wrap_b3", 1'b1, {c, 4'h6});
      c = c + 4'd1;
      bit1("wrap_b4", 1'b1, {c, 4'h9});
    end
    check8("wrap_final", uo_out, 8'h09);

    // Mid-sequence reset discards partial match
    do_reset("mid_rst0");
    bit1("mid_b1", 1'b1, 8'h02);
    bit1("mid_b2", 1'b0, 8'h04);
    bit1("mid_b3", 1'b1, 8'h06);
    step("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    bit1("mid_b4", 1'b1, 8'h02);
    check8("uio_out_end", uio_out, 8'h00);
    check8("uio_oe_end", uio_oe, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
